// File: rtl/fp_byte_link.sv
// Byte-serial front end for a 32-bit FP add/sub core: collects a 9-byte command
// frame, drives the core operands, samples its result and streams it back as 4 bytes.
module fp_byte_link #(
  parameter int WAIT_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int BIG_ENDIAN     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_sub,
  input  logic [31:0] core_result,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [2:0]    state;
  logic [1:0]    byte_cnt;
  logic [1:0]    send_cnt;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   result;

  logic       in_fire;
  logic       out_fire;
  logic [1:0] in_lane;
  logic [1:0] out_lane;

  assign in_ready  = (state == S_IDLE) || (state == S_LOAD_A) || (state == S_LOAD_B);
  assign out_valid = (state == S_SEND);
  assign busy      = (state != S_IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Byte k of a word lands in lane k (LSB first) or lane 3-k (MSB first).
  assign in_lane  = (BIG_ENDIAN != 0) ? ~byte_cnt : byte_cnt;
  assign out_lane = (BIG_ENDIAN != 0) ? ~send_cnt : send_cnt;
  assign out_data = out_valid ? result[{out_lane, 3'b000} +: 8] : 8'h00;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let one register see another's new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      byte_cnt  <= 2'd0;
      send_cnt  <= 2'd0;
      wait_cnt  <= '0;
      tmo_cnt   <= '0;
      result    <= 32'h0;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      op_sub    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_fire) begin
            if (in_data[7:1] == 7'd0) begin
              op_sub   <= in_data[0];
              byte_cnt <= 2'd0;
              tmo_cnt  <= '0;
              state    <= S_LOAD_A;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        S_LOAD_A, S_LOAD_B: begin
          if (in_fire) begin
            tmo_cnt  <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == S_LOAD_A) op_a[{in_lane, 3'b000} +: 8] <= in_data;
            else                   op_b[{in_lane, 3'b000} +: 8] <= in_data;
            if (byte_cnt == 2'd3) state <= (state == S_LOAD_A) ? S_LOAD_B : S_WAIT;
          end else if (TIMEOUT_CYCLES != 0) begin
            // Abort on the edge where the idle count reaches TIMEOUT_CYCLES.
            if (tmo_cnt == TMO_LAST) begin
              state     <= S_IDLE;
              frame_err <= 1'b1;
              byte_cnt  <= 2'd0;
              tmo_cnt   <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            result   <= core_result;
            wait_cnt <= '0;
            send_cnt <= 2'd0;
            state    <= S_SEND;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        S_SEND: begin
          if (out_fire) begin
            send_cnt <= send_cnt + 2'd1;
            if (send_cnt == 2'd3) state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_byte_link.sv
// Bench for fp_byte_link: a table of frames checked through an output-byte
// scoreboard, plus hand-written bad-command, timeout and reset-in-SEND sequences.
module tb_fp_byte_link;

  localparam int BE = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        op_sub;
  logic [31:0] core_result;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  fp_byte_link #(.WAIT_CYCLES(1), .TIMEOUT_CYCLES(8), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .core_result(core_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Core stand-in: exact IEEE results for the known frames, integer math otherwise.
  function automatic logic [31:0] core_fn(logic [31:0] a, logic [31:0] b, logic s);
    if (!s && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (s && a == 32'h40A00000 && b == 32'h3F800000) return 32'h40800000;
    return s ? a - b : a + b;
  endfunction

  always_comb core_result = core_fn(op_a, op_b, op_sub);

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = always ready, 1 = toggle every cycle, 2 = held low
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard of expected output bytes and the output-side monitor.
  logic [7:0] exp_q[$];
  int   valid_cycles = 0;
  int   pops = 0;
  int   fe_count = 0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_err) fe_count++;
      if (prev_stall) begin
        check(out_valid == 1'b1, "stall_valid_hold", {31'd0, out_valid}, 32'd1);
        check(out_data == prev_data, "stall_data_hold", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_byte", {24'd0, out_data}, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check(out_data == e, "out_byte", {24'd0, out_data}, {24'd0, e});
        end
        pops++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check(1'b0, "in_ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*((BE != 0) ? 3 - k : k) +: 8]);
  endtask

  task automatic push_result(input logic [31:0] r);
    for (int k = 0; k < 4; k++) exp_q.push_back(r[8*((BE != 0) ? 3 - k : k) +: 8]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(exp_q.size() == 0 && !busy, "done_timeout", exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          mode;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input string tag);
    int fe0;
    fe0 = fe_count;
    ready_mode   = v.mode;
    valid_cycles = 0;
    push_result(v.exp);
    send_byte(v.cmd);
    send_word(v.a);
    send_word(v.b);
    // Last B byte accepted on edge N: WAIT during the next cycle, SEND after N+1.
    @(negedge clk);
    check(out_valid == 1'b0, {tag, "_lat_wait"}, {31'd0, out_valid}, 32'd0);
    check(op_a == v.a, {tag, "_op_a"}, op_a, v.a);
    check(op_b == v.b, {tag, "_op_b"}, op_b, v.b);
    check(op_sub == v.cmd[0], {tag, "_op_sub"}, {31'd0, op_sub}, {31'd0, v.cmd[0]});
    @(negedge clk);
    check(out_valid == 1'b1, {tag, "_lat_send"}, {31'd0, out_valid}, 32'd1);
    wait_done();
    if (v.mode == 0) check(valid_cycles == 4, {tag, "_valid_cycles"}, valid_cycles, 32'd4);
    check(fe_count == fe0, {tag, "_no_frame_err"}, fe_count - fe0, 32'd0);
    check(in_ready == 1'b1, {tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int hit;
    int n;

    vecs[0] = '{cmd: 8'h00, a: 32'h3F800000, b: 32'h40000000, exp: 32'h40400000, mode: 0};
    vecs[1] = '{cmd: 8'h01, a: 32'h40A00000, b: 32'h3F800000, exp: 32'h40800000, mode: 1};
    vecs[2] = '{cmd: 8'h00, a: 32'h12345678, b: 32'h01010101, exp: 32'h13355779, mode: 0};
    vecs[3] = '{cmd: 8'h01, a: 32'hDEADBEEF, b: 32'h11111111, exp: 32'hCD9CADDE, mode: 1};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(in_ready == 1'b1, "rst_in_ready", {31'd0, in_ready}, 32'd1);
    check(out_valid == 1'b0, "rst_out_valid", {31'd0, out_valid}, 32'd0);
    check(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'd0);
    check(op_a == 32'd0, "rst_op_a", op_a, 32'd0);
    check(op_b == 32'd0, "rst_op_b", op_b, 32'd0);
    check(frame_err == 1'b0, "rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reserved command bit set: one-cycle error, stay idle, then recover.
    send_byte(8'h02);
    @(negedge clk);
    check(frame_err == 1'b1, "badcmd_pulse", {31'd0, frame_err}, 32'd1);
    check(busy == 1'b0, "badcmd_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check(frame_err == 1'b0, "badcmd_one_cycle", {31'd0, frame_err}, 32'd0);
    run_vec(vecs[2], "after_badcmd");

    // Timeout after command plus two A bytes.
    ready_mode   = 0;
    valid_cycles = 0;
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    hit = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (frame_err && hit == 0) hit = i;
    end
    // Counter reaches 8 on the 8th idle edge; the pulse is visible right after it.
    check(hit == 9, "timeout_cycle", hit, 32'd9);
    check(busy == 1'b0, "timeout_idle", {31'd0, busy}, 32'd0);
    check(op_a[15:0] == 16'h2211, "timeout_op_a_kept", {16'd0, op_a[15:0]}, 32'h2211);
    check(valid_cycles == 0, "timeout_no_out", valid_cycles, 32'd0);
    run_vec(vecs[1], "after_timeout");

    // Reset while SEND is mid-result.
    ready_mode = 0;
    pops       = 0;
    push_result(vecs[3].exp);
    send_byte(vecs[3].cmd);
    send_word(vecs[3].a);
    send_word(vecs[3].b);
    n = 0;
    while (pops < 2 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(pops == 2, "rst_send_reach", pops, 32'd2);
    ready_mode = 2;
    out_ready  = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(out_valid == 1'b0, "rst_send_out_valid", {31'd0, out_valid}, 32'd0);
    check(busy == 1'b0, "rst_send_busy", {31'd0, busy}, 32'd0);
    check(op_a == 32'd0 && op_b == 32'd0, "rst_send_ops", op_a | op_b, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    run_vec(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
